clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi.sv | 137 +++++++++++++
 tb/tb_clk_div_multi.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   NUM_CH independent programmable clock dividers sharing one system clock.
//   Each channel counts 0..div_act-1 while enabled. It emits a one-cycle
//   `tick` after each terminal count and a registered square wave `clk_out`
//   that is high for the first floor(div/2) counts of every period.
//   New divisors are staged in a pending register and take effect only at a
//   period boundary, so no period is ever truncated or stretched.
//
// Ports
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : per-channel run enable (disabled -> counter parked at 0)
//   sync_clr   : restart all channels at count 0, applying pending divisors
//   cfg_we     : one-cycle divisor write strobe
//   cfg_ch     : channel targeted by the write
//   cfg_div    : new divisor (must be >= 2)
//   tick       : one-cycle pulse per period, per channel
//   clk_out    : divided square wave, per channel
//   cfg_err    : one-cycle pulse after a rejected write
// -----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = 27,
  parameter int DIV_RST = 100000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic              cfg_err
);

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RST);

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  div_act_q  [NUM_CH];
  logic [CNT_W-1:0]  div_act_d  [NUM_CH];
  logic [CNT_W-1:0]  div_pend_q [NUM_CH];
  logic [CNT_W-1:0]  div_pend_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q,    pend_d;
  logic [NUM_CH-1:0] tick_q,    tick_d;
  logic [NUM_CH-1:0] clk_out_q, clk_out_d;
  logic              cfg_err_q, cfg_err_d;

  logic cfg_ok;
  logic tc;
  logic reload;

  // A write is accepted only for an existing channel and a divisor of at
  // least 2; a divisor of 0 or 1 would make the terminal count ill-defined.
  assign cfg_ok = cfg_we && (32'(cfg_ch) < 32'(NUM_CH)) && (cfg_div >= CNT_W'(2));

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    cfg_err_d = cfg_we && !cfg_ok;
    tc        = 1'b0;
    reload    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]      = cnt_q[i];
      div_act_d[i]  = div_act_q[i];
      div_pend_d[i] = div_pend_q[i];
      pend_d[i]     = pend_q[i];
      tick_d[i]     = 1'b0;
      reload        = 1'b0;
      tc            = en[i] && (cnt_q[i] == div_act_q[i] - CNT_W'(1));

      // sync_clr outranks both the terminal count and the enable.
      if (sync_clr || !en[i]) begin
        cnt_d[i] = '0;
        reload   = 1'b1;
      end else if (tc) begin
        cnt_d[i]  = '0;
        reload    = 1'b1;
        tick_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      // Reload uses the pending state as it stood before this cycle's write,
      // so a write coinciding with a boundary waits for the next one.
      if (reload && pend_q[i]) begin
        div_act_d[i] = div_pend_q[i];
        pend_d[i]    = 1'b0;
      end

      if (cfg_ok && (cfg_ch == CH_W'(i))) begin
        div_pend_d[i] = cfg_div;
        pend_d[i]     = 1'b1;
      end

      // Compare against the divisor that will be active next cycle so the
      // first period after a divisor change already has the new duty cycle.
      clk_out_d[i] = en[i] && !sync_clr && (cnt_d[i] < (div_act_d[i] >> 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge, independent of statement order.
  // NOTE: the divisor arrays are reset too; their reset value is functional
  // (the power-up rate), not just a tidy initial state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= '0;
        div_act_q[i]  <= DIV_INIT;
        div_pend_q[i] <= DIV_INIT;
      end
      pend_q    <= '0;
      tick_q    <= '0;
      clk_out_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_act_q[i]  <= div_act_d[i];
        div_pend_q[i] <= div_pend_d[i];
      end
      pend_q    <= pend_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_out_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
//   Self-checking bench for clk_div_multi (NUM_CH=3, DIV_RST=10).
//   The reference model tracks, per channel, the cycle index at which the
//   current period started and the period length; expected outputs follow
//   from elapsed-cycle arithmetic. Directed scenarios also check tick spacing
//   and duty against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

  localparam int NCH = 3;
  localparam int CW  = 27;
  localparam int DR  = 10;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b1;
  logic [NCH-1:0] en       = '0;
  logic           sync_clr = 1'b0;
  logic           cfg_we   = 1'b0;
  logic [1:0]     cfg_ch   = '0;
  logic [CW-1:0]  cfg_div  = '0;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] clk_out;
  logic           cfg_err;

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(CW), .DIV_RST(DR)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync_clr(sync_clr),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .tick    (tick),
    .clk_out (clk_out),
    .cfg_err (cfg_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int             now;           // index of the cycle currently in progress
  int             m_start[NCH];  // cycle index where the current period began
  int             m_per  [NCH];  // active period length
  int             m_pdiv [NCH];  // staged period length
  bit             m_pend [NCH];
  logic [NCH-1:0] m_tick;
  logic [NCH-1:0] m_clk;
  logic           m_err;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_per[i]   = DR;
      m_pdiv[i]  = DR;
      m_pend[i]  = 1'b0;
      m_start[i] = now;
    end
    m_tick = '0;
    m_clk  = '0;
    m_err  = 1'b0;
  endtask

  // Advance one clock: the model consumes the inputs seen at the edge, then
  // outputs are sampled 1 ns later. Inputs are changed only after this returns.
  task automatic step();
    bit fin;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        fin = en[i] && !sync_clr && (now - m_start[i] == m_per[i] - 1);
        if (!en[i] || sync_clr || fin) begin
          m_start[i] = now + 1;
          if (m_pend[i]) begin
            m_per[i]  = m_pdiv[i];
            m_pend[i] = 1'b0;
          end
        end
        m_tick[i] = fin;
        if (cfg_we && int'(cfg_ch) == i && cfg_div >= 2) begin
          m_pdiv[i] = int'(cfg_div);
          m_pend[i] = 1'b1;
        end
        m_clk[i] = en[i] && !sync_clr && ((now + 1 - m_start[i]) < m_per[i] / 2);
      end
      m_err = cfg_we && (cfg_ch >= 2'(NCH) || cfg_div < 2);
    end
    now++;
    #1;
  endtask

  function automatic int pos(int ch);
    return now - m_start[ch];
  endfunction

  task automatic write_cfg(input int ch, input int dv);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = CW'(dv);
    step();
    cfg_we  = 1'b0;
    n_tests++;
    if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
      n_fail++;
      $display("FAIL write_cfg ch%0d: got %b exp %b", ch, {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    now = 0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tick, clk_out, cfg_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_async: got %b exp %b", {tick, clk_out, cfg_err}, 7'b0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step();
    n_tests++;
    if ({tick, clk_out, cfg_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b exp %b", {tick, clk_out, cfg_err}, 7'b0);
    end
  endtask

  task automatic test_basic();
    int first_tick = -1;
    int hi = 0;
    en = 3'b111;
    for (int k = 1; k <= 30; k++) begin
      step();
      n_tests++;
      if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
        n_fail++;
        $display("FAIL basic k=%0d: got %b exp %b", k, {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
      end
      if (tick[0] && first_tick < 0) first_tick = k;
      if (k > 10 && k <= 20 && clk_out[0]) hi++;
    end
    n_tests++;
    if (first_tick !== 10) begin
      n_fail++;
      $display("FAIL basic_first_tick: got %0d exp 10", first_tick);
    end
    n_tests++;
    if (hi !== 5) begin
      n_fail++;
      $display("FAIL basic_duty: got %0d high exp 5", hi);
    end
  endtask

  task automatic test_retime();
    int n;
    n = 0;
    while (pos(1) != 3 && n < 20) begin
      step();
      n++;
      n_tests++;
      if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
        n_fail++;
        $display("FAIL retime_wait: got %b exp %b", {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
      end
    end
    n_tests++;
    if (pos(1) != 3) begin
      n_fail++;
      $display("FAIL retime_align: timeout, pos %0d exp 3", pos(1));
    end
    write_cfg(1, 4);
    for (int leg = 0; leg < 3; leg++) begin
      n = 0;
      do begin
        step();
        n++;
        n_tests++;
        if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
          n_fail++;
          $display("FAIL retime_run: got %b exp %b", {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
        end
      end while (!tick[1] && n < 50);
      n_tests++;
      if (n !== ((leg == 0) ? 6 : 4)) begin
        n_fail++;
        $display("FAIL retime_gap%0d: got %0d exp %0d", leg, n, (leg == 0) ? 6 : 4);
      end
    end
  endtask

  task automatic test_tc_write();
    int n;
    int hi;
    n = 0;
    while (pos(0) != 9 && n < 20) begin
      step();
      n++;
    end
    n_tests++;
    if (pos(0) != 9) begin
      n_fail++;
      $display("FAIL tcw_align: timeout, pos %0d exp 9", pos(0));
    end
    write_cfg(0, 7);
    n_tests++;
    if (tick[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL tcw_tick: got %b exp 1", tick[0]);
    end
    for (int leg = 0; leg < 2; leg++) begin
      n  = 0;
      hi = 0;
      do begin
        step();
        n++;
        if (clk_out[0]) hi++;
        n_tests++;
        if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
          n_fail++;
          $display("FAIL tcw_run: got %b exp %b", {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
        end
      end while (!tick[0] && n < 50);
      n_tests++;
      if (n !== ((leg == 0) ? 10 : 7)) begin
        n_fail++;
        $display("FAIL tcw_gap%0d: got %0d exp %0d", leg, n, (leg == 0) ? 10 : 7);
      end
    end
    n_tests++;
    if (hi !== 3) begin
      n_fail++;
      $display("FAIL tcw_duty7: got %0d high exp 3", hi);
    end
  endtask

  task automatic test_err();
    int n;
    write_cfg(1, 1);
    n_tests++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_div1: got %b exp 1", cfg_err);
    end
    write_cfg(3, 5);
    n_tests++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_ch3: got %b exp 1", cfg_err);
    end
    step();
    n_tests++;
    if (cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b exp 0", cfg_err);
    end
    // Channel 1 must keep its 4-cycle period.
    n = 0;
    while (!tick[1] && n < 20) begin step(); n++; end
    n = 0;
    do begin
      step();
      n++;
      n_tests++;
      if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
        n_fail++;
        $display("FAIL err_run: got %b exp %b", {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
      end
    end while (!tick[1] && n < 50);
    n_tests++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL err_div_kept: got %0d exp 4", n);
    end
  endtask

  task automatic test_sync_clr();
    int first_all = -1;
    write_cfg(0, 10);
    write_cfg(1, 6);
    write_cfg(2, 4);
    repeat ($urandom_range(15)) step();
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    n_tests++;
    if ({tick, clk_out} !== 6'b0) begin
      n_fail++;
      $display("FAIL sclr_zero: got %b exp %b", {tick, clk_out}, 6'b0);
    end
    for (int k = 1; k <= 60; k++) begin
      step();
      n_tests++;
      if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
        n_fail++;
        $display("FAIL sclr_run k=%0d: got %b exp %b", k, {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
      end
      if (tick === 3'b111 && first_all < 0) first_all = k;
    end
    n_tests++;
    if (first_all !== 60) begin
      n_fail++;
      $display("FAIL sclr_lcm: got %0d exp 60", first_all);
    end
  endtask

  task automatic test_disable();
    int n;
    n = 0;
    while (pos(2) != 1 && n < 20) begin step(); n++; end
    write_cfg(2, 8);
    en[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_tests++;
      if ({tick[2], clk_out[2]} !== 2'b00 || {tick, clk_out} !== {m_tick, m_clk}) begin
        n_fail++;
        $display("FAIL dis_low: got %b exp %b", {tick, clk_out}, {m_tick, m_clk});
      end
    end
    en[2] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      n_tests++;
      if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
        n_fail++;
        $display("FAIL dis_run: got %b exp %b", {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
      end
    end while (!tick[2] && n < 50);
    n_tests++;
    if (n !== 8) begin
      n_fail++;
      $display("FAIL dis_first_tick: got %0d exp 8", n);
    end
    // Mid-period reset with a write still pending on channel 1.
    repeat (3) step();
    write_cfg(1, 3);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tick, clk_out, cfg_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got %b exp %b", {tick, clk_out, cfg_err}, 7'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    n = 0;
    do begin
      step();
      n++;
      n_tests++;
      if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
        n_fail++;
        $display("FAIL midrst_run: got %b exp %b", {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
      end
    end while (!tick[0] && n < 50);
    n_tests++;
    if (n !== 10 || tick !== 3'b111) begin
      n_fail++;
      $display("FAIL midrst_div: got n=%0d tick=%b exp n=10 tick=111", n, tick);
    end
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < NCH; i++) en[i] = ($urandom_range(99) < 92);
      sync_clr = ($urandom_range(99) < 2);
      cfg_we   = ($urandom_range(99) < 15);
      cfg_ch   = 2'($urandom_range(3));
      r        = $urandom_range(15);
      cfg_div  = CW'(r);
      step();
      n_tests++;
      if ({tick, clk_out, cfg_err} !== {m_tick, m_clk, m_err}) begin
        n_fail++;
        $display("FAIL random k=%0d: got %b exp %b", k, {tick, clk_out, cfg_err}, {m_tick, m_clk, m_err});
      end
    end
    cfg_we   = 1'b0;
    sync_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_retime();
    test_tc_write();
    test_err();
    test_sync_clr();
    test_disable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
